// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants for instr_encoder: operator group codes, 5-bit
// instruction suffixes and small field-packing helpers.
package instr_encoder_pkg;

    localparam logic [3:0] GROUP_CRVMATH       = 4'd0;
    localparam logic [3:0] GROUP_RJMP          = 4'd1;
    localparam logic [3:0] GROUP_CRRMATH       = 4'd2;
    localparam logic [3:0] GROUP_CRSMATH       = 4'd3;
    localparam logic [3:0] GROUP_WRRMATH       = 4'd4;
    localparam logic [3:0] GROUP_WRRMATH_MEM   = 4'd5;
    localparam logic [3:0] GROUP_WRSMATH       = 4'd6;
    localparam logic [3:0] GROUP_WRSMATH_STACK = 4'd7;
    localparam logic [3:0] GROUP_SFLAG         = 4'd8;
    localparam logic [3:0] GROUP_UFLAG         = 4'd9;
    localparam logic [3:0] GROUP_SPECIAL       = 4'd10;
    localparam logic [3:0] GROUP_SPECIAL_LONG  = 4'd11;

    localparam logic [4:0] SFX_CRR     = 5'b00111;
    localparam logic [4:0] SFX_CRS     = 5'b01111;
    localparam logic [4:0] SFX_WRR     = 5'b10111;
    localparam logic [4:0] SFX_WRS     = 5'b11111;
    localparam logic [4:0] SFX_SFLAG   = 5'b00011;
    localparam logic [4:0] SFX_UFLAG   = 5'b10011;
    localparam logic [4:0] SFX_SPECIAL = 5'b11011;

    function automatic logic [15:0] reg_form(input logic [3:0] op,
                                             input logic [2:0] rg2,
                                             input logic [2:0] rg1,
                                             input logic [4:0] sfx);
        return {op, 1'b0, rg2, rg1, sfx};
    endfunction

    // op[3:1] == 111 selects the stack / long variants.
    function automatic logic op_is_top(input logic [3:0] op);
        return (op[3:1] == 3'b111);
    endfunction

    // 1011 and 1111 are register-only forms even though op[3] is set.
    function automatic logic op_is_reg_alias(input logic [3:0] op);
        return (op == 4'b1011) || (op == 4'b1111);
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: decoded fields -> 16-bit word, legality, long flag.
// Legality checks are compiled in only with INSTR_ENCODER_CHECK_EN.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  group,
    input  logic [3:0]  operator,
    input  logic [2:0]  rg1,
    input  logic [2:0]  rg2,
    input  logic [7:0]  val,
    input  logic [7:0]  flags,
    input  logic [9:0]  relative_addr,
    output logic [15:0] word,
    output logic        legal,
    output logic        is_long
);

    // Per-group encoding and legality.
    always_comb begin
        word    = 16'h0000;
        legal   = 1'b1;
        is_long = 1'b0;
        case (group)
            GROUP_CRVMATH: word = {operator, val, rg1, 1'b0};
            GROUP_RJMP:    word = {operator, relative_addr, 2'b01};
            GROUP_CRRMATH: word = reg_form(operator, rg2, rg1, SFX_CRR);
            GROUP_CRSMATH: word = reg_form(operator, rg2, rg1, SFX_CRS);
            GROUP_WRRMATH: begin
                word = reg_form(operator, rg2, rg1, SFX_WRR);
`ifdef INSTR_ENCODER_CHECK_EN
                legal = ~operator[3] | op_is_reg_alias(operator);
`endif
            end
            GROUP_WRRMATH_MEM: begin
                word = reg_form(operator, rg2, rg1, SFX_WRR);
`ifdef INSTR_ENCODER_CHECK_EN
                legal = operator[3] & ~op_is_reg_alias(operator);
`endif
            end
            GROUP_WRSMATH: begin
                word = reg_form(operator, rg2, rg1, SFX_WRS);
`ifdef INSTR_ENCODER_CHECK_EN
                legal = ~op_is_top(operator);
`endif
            end
            GROUP_WRSMATH_STACK: begin
                word = reg_form(operator, rg2, rg1, SFX_WRS);
`ifdef INSTR_ENCODER_CHECK_EN
                legal = op_is_top(operator);
`endif
            end
            GROUP_SFLAG:   word = {flags, 3'b000, SFX_SFLAG};
            GROUP_UFLAG:   word = {flags, 3'b000, SFX_UFLAG};
            GROUP_SPECIAL: begin
                word = reg_form(operator, rg2, rg1, SFX_SPECIAL);
`ifdef INSTR_ENCODER_CHECK_EN
                legal = ~op_is_top(operator);
`endif
            end
            GROUP_SPECIAL_LONG: begin
                word    = reg_form(operator, rg2, rg1, SFX_SPECIAL);
                is_long = 1'b1;
`ifdef INSTR_ENCODER_CHECK_EN
                legal = op_is_top(operator);
`endif
            end
            default: begin
                // Unassigned group codes fall back to the SPECIAL form.
                word = reg_form(operator, rg2, rg1, SFX_SPECIAL);
`ifdef INSTR_ENCODER_CHECK_EN
                legal = 1'b0;
`endif
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: packs field bundles into program words with a
// running target address. Define INSTR_ENCODER_CHECK_EN to enable legality/err.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        group,
    input  logic [3:0]        operator,
    input  logic [2:0]        rg1,
    input  logic [2:0]        rg2,
    input  logic [7:0]        val,
    input  logic [7:0]        flags,
    input  logic [9:0]        relative_addr,
    input  logic [15:0]       imm16,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } state_e;

    state_e            state_r;
    state_e            state_s;
    logic              in_ready_s;
    logic              out_valid_r;
    logic [15:0]       out_word_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic              err_r;
    logic              long_r;
    logic [15:0]       imm_r;

    logic [15:0]       pack_word_s;
    logic              pack_legal_s;
    logic              pack_long_s;
    logic              accept_s;
    logic              accept_legal_s;
    logic              hs_s;

    instr_pack u_pack (
        .group         (group),
        .operator      (operator),
        .rg1           (rg1),
        .rg2           (rg2),
        .val           (val),
        .flags         (flags),
        .relative_addr (relative_addr),
        .word          (pack_word_s),
        .legal         (pack_legal_s),
        .is_long       (pack_long_s)
    );

    assign accept_s       = in_valid & in_ready_s;
    assign accept_legal_s = accept_s & pack_legal_s;
    assign hs_s           = out_valid_r & out_ready;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_word  = out_word_r;
    assign out_addr  = out_addr_r;
    assign err       = err_r;

    // Next-state and input-side ready.
    always_comb begin
        state_s    = state_r;
        in_ready_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                in_ready_s = 1'b1;
                if (accept_legal_s) begin
                    state_s = ST_FIRST;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_FIRST: begin
                in_ready_s = out_ready & ~long_r;
                if (!hs_s) begin
                    state_s = ST_FIRST;
                end else if (long_r) begin
                    state_s = ST_SECOND;
                end else if (accept_legal_s) begin
                    state_s = ST_FIRST;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_SECOND: begin
                in_ready_s = out_ready;
                if (!hs_s) begin
                    state_s = ST_SECOND;
                end else if (accept_legal_s) begin
                    state_s = ST_FIRST;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            default: begin
                in_ready_s = 1'b0;
                state_s    = ST_EMPTY;
            end
        endcase
    end

    // State, output word/address registers and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            out_word_r  <= 16'h0000;
            out_addr_r  <= {ADDR_W{1'b0}};
            err_r       <= 1'b0;
            long_r      <= 1'b0;
            imm_r       <= 16'h0000;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s != ST_EMPTY);
            if (accept_legal_s) begin
                out_word_r <= pack_word_s;
                long_r     <= pack_long_s;
                imm_r      <= imm16;
            end else if (hs_s && (state_r == ST_FIRST) && long_r) begin
                out_word_r <= imm_r;
                long_r     <= 1'b0;
            end else begin
                out_word_r <= out_word_r;
                long_r     <= long_r;
            end
            // The address register is the pending word's address, so a load
            // also retargets a word that is still waiting for out_ready.
            if (load) begin
                out_addr_r <= load_addr;
            end else if (hs_s) begin
                out_addr_r <= out_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                out_addr_r <= out_addr_r;
            end
`ifdef INSTR_ENCODER_CHECK_EN
            err_r <= accept_s & ~pack_legal_s;
`else
            err_r <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand sequences
// and randomized traffic against a word-queue reference model.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

`ifdef INSTR_ENCODER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready8;
    logic [3:0]  group, operator;
    logic [2:0]  rg1, rg2;
    logic [7:0]  val, flags;
    logic [9:0]  relative_addr;
    logic [15:0] imm16;
    logic        load;
    logic [15:0] load_addr;
    logic        out_valid, out_valid8;
    logic        out_ready;
    logic [15:0] out_word, out_word8;
    logic [15:0] out_addr;
    logic [7:0]  out_addr8;
    logic        err, err8;

    int nchecks = 0;
    int nerr = 0;

    logic [15:0] pend[$];
    logic [15:0] m_addr;
    logic        m_err;

    typedef struct {
        logic [3:0]  g;
        logic [3:0]  op;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [7:0]  v;
        logic [7:0]  f;
        logic [9:0]  ra;
        logic [15:0] imm;
        logic [15:0] w1;
        logic [15:0] w2;
        bit          lng;
        bit          lgl;
    } vec_t;
    vec_t vecs[12];

    instr_encoder #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .group(group), .operator(operator), .rg1(rg1), .rg2(rg2), .val(val),
        .flags(flags), .relative_addr(relative_addr), .imm16(imm16),
        .load(load), .load_addr(load_addr), .out_valid(out_valid),
        .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr), .err(err)
    );

    instr_encoder #(.ADDR_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .group(group), .operator(operator), .rg1(rg1), .rg2(rg2), .val(val),
        .flags(flags), .relative_addr(relative_addr), .imm16(imm16),
        .load(load), .load_addr(load_addr[7:0]), .out_valid(out_valid8),
        .out_ready(out_ready), .out_word(out_word8), .out_addr(out_addr8), .err(err8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference encoding written from the field layout with plain arithmetic.
    task automatic enc(input logic [3:0] g, input logic [3:0] op, input logic [2:0] r1,
                       input logic [2:0] r2, input logic [7:0] v, input logic [7:0] f,
                       input logic [9:0] ra, output logic lg, output logic lng,
                       output logic [15:0] w);
        int sfx;
        int x;
        int opn;
        opn = int'(op);
        lng = (g == GROUP_SPECIAL_LONG);
        lg  = 1'b1;
        sfx = 27;
        if (g == GROUP_CRRMATH) sfx = 7;
        else if (g == GROUP_CRSMATH) sfx = 15;
        else if (g == GROUP_WRRMATH || g == GROUP_WRRMATH_MEM) sfx = 23;
        else if (g == GROUP_WRSMATH || g == GROUP_WRSMATH_STACK) sfx = 31;
        else sfx = 27;
        if (g == GROUP_CRVMATH) x = opn * 4096 + int'(v) * 16 + int'(r1) * 2;
        else if (g == GROUP_RJMP) x = opn * 4096 + int'(ra) * 4 + 1;
        else if (g == GROUP_SFLAG) x = int'(f) * 256 + 3;
        else if (g == GROUP_UFLAG) x = int'(f) * 256 + 19;
        else x = opn * 4096 + int'(r2) * 256 + int'(r1) * 32 + sfx;
        w = x[15:0];
        if (CHK) begin
            if (g == GROUP_WRRMATH_MEM) lg = (opn >= 8) && (opn != 11) && (opn != 15);
            else if (g == GROUP_WRRMATH) lg = (opn < 8) || (opn == 11) || (opn == 15);
            else if (g == GROUP_WRSMATH_STACK || g == GROUP_SPECIAL_LONG) lg = (opn >= 14);
            else if (g == GROUP_WRSMATH || g == GROUP_SPECIAL) lg = (opn < 14);
            else if (g > GROUP_SPECIAL_LONG) lg = 1'b0;
            else lg = 1'b1;
        end
    endtask

    // One clock: check ready, advance the model, then check registered outputs.
    task automatic cycle();
        logic lg, lng;
        logic [15:0] w;
        bit hs, acc, mr;
        #1;
        mr = (pend.size() == 0) || (out_ready && pend.size() == 1);
        if (!rst) chk("in_ready", in_ready, mr);
        enc(group, operator, rg1, rg2, val, flags, relative_addr, lg, lng, w);
        hs  = out_ready && (pend.size() > 0);
        acc = in_valid && mr;
        if (rst) begin
            pend.delete();
            m_addr = 16'h0000;
            m_err  = 1'b0;
        end else begin
            if (load) m_addr = load_addr;
            else if (hs) m_addr = m_addr + 16'h0001;
            if (hs) void'(pend.pop_front());
            m_err = acc && !lg;
            if (acc && lg) begin
                pend.push_back(w);
                if (lng) pend.push_back(imm16);
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, pend.size() > 0);
        if (pend.size() > 0) begin
            chk("out_word", out_word, pend[0]);
            chk("out_addr", out_addr, m_addr);
        end
        chk("err", err, m_err);
    endtask

    task automatic set_bundle(input logic [3:0] g, input logic [3:0] op, input logic [2:0] r1,
                              input logic [2:0] r2, input logic [7:0] v, input logic [7:0] f,
                              input logic [9:0] ra, input logic [15:0] imm);
        group = g; operator = op; rg1 = r1; rg2 = r2; val = v; flags = f;
        relative_addr = ra; imm16 = imm;
    endtask

    initial begin
        vecs[0]  = '{GROUP_CRVMATH,       4'h3, 3'd5, 3'd0, 8'hA5, 8'h00, 10'h000, 16'h0000, 16'h3A5A, 16'h0000, 1'b0, 1'b1};
        vecs[1]  = '{GROUP_RJMP,          4'h2, 3'd0, 3'd0, 8'h00, 8'h00, 10'h155, 16'h0000, 16'h2555, 16'h0000, 1'b0, 1'b1};
        vecs[2]  = '{GROUP_SFLAG,         4'h0, 3'd0, 3'd0, 8'h00, 8'hA5, 10'h000, 16'h0000, 16'hA503, 16'h0000, 1'b0, 1'b1};
        vecs[3]  = '{GROUP_UFLAG,         4'h0, 3'd0, 3'd0, 8'h00, 8'h3C, 10'h000, 16'h0000, 16'h3C13, 16'h0000, 1'b0, 1'b1};
        vecs[4]  = '{GROUP_CRRMATH,       4'h1, 3'd3, 3'd2, 8'h00, 8'h00, 10'h000, 16'h0000, 16'h1267, 16'h0000, 1'b0, 1'b1};
        vecs[5]  = '{GROUP_CRSMATH,       4'h4, 3'd1, 3'd7, 8'h00, 8'h00, 10'h000, 16'h0000, 16'h472F, 16'h0000, 1'b0, 1'b1};
        vecs[6]  = '{GROUP_WRRMATH,       4'h2, 3'd6, 3'd1, 8'h00, 8'h00, 10'h000, 16'h0000, 16'h21D7, 16'h0000, 1'b0, 1'b1};
        vecs[7]  = '{GROUP_WRSMATH,       4'h0, 3'd0, 3'd0, 8'h00, 8'h00, 10'h000, 16'h0000, 16'h001F, 16'h0000, 1'b0, 1'b1};
        vecs[8]  = '{GROUP_WRRMATH_MEM,   4'h9, 3'd2, 3'd3, 8'h00, 8'h00, 10'h000, 16'h0000, 16'h9357, 16'h0000, 1'b0, 1'b1};
        vecs[9]  = '{GROUP_WRSMATH_STACK, 4'hF, 3'd4, 3'd5, 8'h00, 8'h00, 10'h000, 16'h0000, 16'hF59F, 16'h0000, 1'b0, 1'b1};
        vecs[10] = '{GROUP_WRRMATH_MEM,   4'hB, 3'd0, 3'd0, 8'h00, 8'h00, 10'h000, 16'h0000, 16'hB017, 16'h0000, 1'b0, !CHK};
        vecs[11] = '{4'd13,               4'h5, 3'd0, 3'd0, 8'h00, 8'h00, 10'h000, 16'h0000, 16'h501B, 16'h0000, 1'b0, !CHK};

        rst = 1'b1; in_valid = 1'b0; load = 1'b0; load_addr = 16'h0000; out_ready = 1'b0;
        set_bundle(4'h0, 4'h0, 3'd0, 3'd0, 8'h00, 8'h00, 10'h000, 16'h0000);
        pend.delete(); m_addr = 16'h0000; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_word", out_word, 16'h0000);
        chk("rst_out_addr", out_addr, 16'h0000);
        chk("rst_err", err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);

        // Vector table, one bundle at a time with the sink always ready.
        for (int i = 0; i < 12; i++) begin
            set_bundle(vecs[i].g, vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].v,
                       vecs[i].f, vecs[i].ra, vecs[i].imm);
            in_valid = 1'b1; out_ready = 1'b1;
            cycle();
            in_valid = 1'b0;
            chk("vec_valid", out_valid, vecs[i].lgl);
            chk("vec_err", err, !vecs[i].lgl);
            if (vecs[i].lgl) chk("vec_word", out_word, vecs[i].w1);
            if (i == 0) chk("vec_first_addr", out_addr, 16'h0000);
            cycle();
            cycle();
        end

        // Load then SPECIAL_LONG: two words at consecutive addresses.
        load = 1'b1; load_addr = 16'h0100;
        cycle();
        load = 1'b0;
        set_bundle(GROUP_SPECIAL_LONG, 4'hE, 3'd0, 3'd0, 8'h00, 8'h00, 10'h000, 16'hBEEF);
        in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        chk("long_w1", out_word, 16'hE01B);
        chk("long_a1", out_addr, 16'h0100);
        cycle();
        in_valid = 1'b0;
        chk("long_w2", out_word, 16'hBEEF);
        chk("long_a2", out_addr, 16'h0101);
        cycle();
        cycle();

        // Back-pressure for three cycles, then back-to-back words.
        set_bundle(GROUP_CRVMATH, 4'h7, 3'd1, 3'd0, 8'h11, 8'h00, 10'h000, 16'h0000);
        in_valid = 1'b1; out_ready = 1'b0;
        cycle();
        set_bundle(GROUP_RJMP, 4'h1, 3'd0, 3'd0, 8'h00, 8'h00, 10'h3FF, 16'h0000);
        repeat (3) cycle();
        out_ready = 1'b1;
        cycle();
        set_bundle(GROUP_SFLAG, 4'h0, 3'd0, 3'd0, 8'h00, 8'h81, 10'h000, 16'h0000);
        cycle();
        set_bundle(GROUP_UFLAG, 4'h0, 3'd0, 3'd0, 8'h00, 8'h42, 10'h000, 16'h0000);
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();

        // Address wrap on the 8-bit instance.
        load = 1'b1; load_addr = 16'h00FF;
        cycle();
        load = 1'b0;
        set_bundle(GROUP_CRVMATH, 4'h3, 3'd5, 3'd0, 8'hA5, 8'h00, 10'h000, 16'h0000);
        in_valid = 1'b1;
        cycle();
        chk("wrap_a8_first", out_addr8, 8'hFF);
        set_bundle(GROUP_RJMP, 4'h2, 3'd0, 3'd0, 8'h00, 8'h00, 10'h155, 16'h0000);
        cycle();
        in_valid = 1'b0;
        chk("wrap_a8_second", out_addr8, 8'h00);
        chk("wrap_w8_second", out_word8, 16'h2555);
        cycle();

        // Reset between the two words of SPECIAL_LONG.
        set_bundle(GROUP_SPECIAL_LONG, 4'hF, 3'd1, 3'd2, 8'h00, 8'h00, 10'h000, 16'h1234);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_addr", out_addr, 16'h0000);
        chk("mid_rst_valid8", out_valid8, 1'b0);
        chk("mid_rst_addr8", out_addr8, 8'h00);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            load      = ($urandom_range(0, 19) == 0);
            load_addr = 16'($urandom);
            rst       = ($urandom_range(0, 99) == 0);
            set_bundle(4'($urandom_range(0, 15)), 4'($urandom), 3'($urandom), 3'($urandom),
                       8'($urandom), 8'($urandom), 10'($urandom), 16'($urandom));
            cycle();
        end
        rst = 1'b0; in_valid = 1'b0; load = 1'b0; out_ready = 1'b1;
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming instruction encoder: the inverse of the CPU instruction decoder. It accepts decoded instruction fields (operator group, operator, registers, immediate, flags, relative address), packs them into 16-bit instruction words in the CPU's encoding, and emits them with a target program-memory address over a valid/ready interface. It sits between the debug/boot loader front end and program-memory write port. It also handles the two-word `GROUP_SPECIAL_LONG` form and checks field legality.

## Interface
- `ADDR_W`, 16: width of the program-memory word address.

- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: field bundle valid.
- `in_ready`  out  1: encoder accepts the bundle this cycle.
- `group`  in  4: operator group, a `GROUP_*` code.
- `operator`  in  4: instruction bits [15:12].
- `rg1`, `rg2`  in  3 each: register fields.
- `val`  in  8: immediate for CRVMATH.
- `flags`  in  8: flag mask for SFLAG/UFLAG.
- `relative_addr`  in  10: RJMP offset.
- `imm16`  in  16: second word for SPECIAL_LONG.
- `load`  in  1: load the address counter.
- `load_addr`  in  ADDR_W: new address.
- `out_valid`  out  1: word valid.
- `out_ready`  in  1: memory-side accept.
- `out_word`  out  16: encoded word.
- `out_addr`  out  ADDR_W: address for `out_word`.
- `err`  out  1: one-cycle pulse on an illegal bundle.

## Operation
- Encoding rules by group (unlisted bits are 0):
  - CRVMATH: {op, val, rg1, 1'b0}.
  - RJMP: {op, relative_addr, 2'b01}.
  - CRRMATH: {op, 1'b0, rg2, rg1, 5'b00111}.
  - CRSMATH: as CRRMATH, with suffix 01111.
  - WRRMATH and WRRMATH_MEM: as CRRMATH, with suffix 10111.
  - WRSMATH and WRSMATH_STACK: suffix 11111.
  - SFLAG: {flags, 3'b000, 5'b00011}.
  - UFLAG: {flags, 3'b000, 5'b10011}.
  - SPECIAL and SPECIAL_LONG: suffix 11011. SPECIAL_LONG then emits `imm16` as a second word.
- Legality checks:
  - WRRMATH_MEM requires op[3]=1 and op ∉ {1011, 1111}.
  - WRRMATH requires op[3]=0 or op ∈ {1011, 1111}.
  - WRSMATH_STACK and SPECIAL_LONG require op[3:1]=111.
  - WRSMATH and SPECIAL require op[3:1]≠111.
  - An undefined group code is illegal.
- Illegal bundle handling: the bundle is consumed (`in_ready` high). No word is emitted, `err` pulses for one cycle, and the address is unchanged.
- State machine:
  - States: EMPTY, FIRST, SECOND.
  - EMPTY → FIRST on an accepted legal bundle.
  - FIRST → SECOND on output handshake if the bundle was SPECIAL_LONG.
  - FIRST → EMPTY on output handshake otherwise, or → FIRST again if a new legal bundle is accepted in the same cycle.
  - SECOND → EMPTY on handshake, or → FIRST on handshake with a new legal bundle accepted.
- `in_ready` = EMPTY | (out_ready & SECOND) | (out_ready & FIRST & ~long_pending).
- Address counter:
  - Increments by 1 per output handshake; wraps modulo 2^ADDR_W.
  - `load` overrides any increment in the same cycle.
  - `load` while `out_valid` also retargets the pending word.

## Timing
- Latency: a bundle accepted in cycle N gives `out_valid` in N+1. For SPECIAL_LONG, the second word appears the cycle after the first handshake.
- Throughput: one word per cycle under continuous `out_ready`.
- `out_word` and `out_addr` are registered and stay stable while `out_valid & ~out_ready`.
- Reset values:
  - state = EMPTY
  - `out_valid` = 0
  - `out_word` = 0
  - `out_addr` = 0
  - `err` = 0
  - `in_ready` = 1 from the first cycle after reset.
- Reset mid-sequence, including between the words of SPECIAL_LONG, drops pending words. The next cycle shows `out_valid` = 0.
- `err` is registered and asserts in cycle N+1.

## Configuration
- `INSTR_ENCODER_CHECK_EN`:
  - Defined: legality checks and `err` are active.
  - Undefined: every bundle is encoded per its group's rule. WRRMATH and WRRMATH_MEM are treated alike, and WRSMATH and WRSMATH_STACK are treated alike. SPECIAL_LONG always emits two words. An undefined group encodes as SPECIAL. `err` is tied 0.

## Structure
- `GROUP_*` codes and the 5-bit suffix constants belong in shared `cpu_data.v`. State encodings stay local.
- One natural sub-module, `instr_pack`: combinational fields → {word, legal, is_long}. The top holds the state machine, output register and address counter.

## Test plan
- CRVMATH, op=3, rg1=5, val=A5 → `out_word` 16'h3A5A at address 0, one cycle after acceptance.
- RJMP, op=2, relative_addr=10'h155 → 16'h2555.
- `load_addr`=16'h0100, then SPECIAL_LONG with op=E, rg1=rg2=0, imm16=BEEF → 16'hE01B @0100, then 16'hBEEF @0101. `in_ready` is low until the second handshake.
- WRRMATH_MEM with op=B, check enabled → `err` pulse, no `out_valid`, address unchanged.
- `out_ready` held low for 3 cycles with a word pending → word and address stable, `in_ready` low. Release → handshake, then back-to-back words at 1 per cycle.
- ADDR_W=8, loaded 8'hFF, two words → addresses FF then 00. Reset asserted between SPECIAL_LONG words → `out_valid`=0 next cycle, `out_addr`=0.
